// File: rtl/instr_issue_unit_if.sv
// Instruction issue unit bus.
// Groups every instr_issue_unit signal except clk/rst.
//   Loader side   : run, in_valid, in_instr -> unit; in_ready <- unit
//   Processor side: instr_out -> processor; result_in <- processor
//   Result report : res_valid, res_data, res_dest, res_opcode
//   Status        : bad_opcode, busy, level
// master = the environment (loader/processor), slave = the issue unit.
interface instr_issue_unit_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          run;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic [31:0]   instr_out;
   logic [31:0]   result_in;
   logic          res_valid;
   logic [31:0]   res_data;
   logic [4:0]    res_dest;
   logic [5:0]    res_opcode;
   logic          bad_opcode;
   logic          busy;
   logic [LW-1:0] level;

   modport master (
      output run, in_valid, in_instr, result_in,
      input  in_ready, instr_out, res_valid, res_data, res_dest, res_opcode,
             bad_opcode, busy, level
   );

   modport slave (
      input  run, in_valid, in_instr, result_in,
      output in_ready, instr_out, res_valid, res_data, res_dest, res_opcode,
             bad_opcode, busy, level
   );
endinterface

// File: rtl/instr_issue_unit.sv
// Instruction issue unit.
// Buffers 32-bit instructions from a loader in a DEPTH-entry FIFO, drops
// entries whose opcode is invalid, holds each valid instruction on
// instr_out for ISSUE_CYCLES cycles and reports the processor result
// captured at the end of that hold window together with dest and opcode.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - instr_issue_unit_if.slave (loader handshake, processor
//          instruction/result, result report, status)
module instr_issue_unit #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned ISSUE_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   instr_issue_unit_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned CW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_e;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;

   state_e        state_q, state_d;
   logic [CW-1:0] hold_q, hold_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   res_data_q, res_data_d;
   logic [4:0]    res_dest_q, res_dest_d;
   logic [5:0]    res_op_q, res_op_d;
   logic          res_valid_q, res_valid_d;
   logic          bad_q, bad_d;

   logic          push, pop;
   logic          in_ready;
   logic          not_empty;
   logic          head_ok;
   logic          hold_done;
   logic [31:0]   head;

   function automatic logic opcode_valid(input logic [5:0] op);
      case (op)
         6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8,
         6'd10, 6'd11, 6'd12, 6'd13, 6'd14: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   // ---------------- FIFO ----------------
   assign in_ready  = (level_q != LW'(DEPTH));
   assign not_empty = (level_q != '0);
   assign push      = bus.in_valid && in_ready;
   assign head      = mem_q[rd_ptr_q];
   assign head_ok   = opcode_valid(head[5:0]);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage needs no reset: emptiness is tracked by level_q alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_instr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // ---------------- issue FSM ----------------
   assign hold_done = (hold_q == CW'(ISSUE_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      instr_d     = instr_q;
      res_data_d  = res_data_q;
      res_dest_d  = res_dest_q;
      res_op_d    = res_op_q;
      res_valid_d = 1'b0;
      bad_d       = 1'b0;
      pop         = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Every inspected entry leaves the FIFO; invalid ones are dropped.
            if (bus.run && not_empty) begin
               pop = 1'b1;
               if (head_ok) begin
                  instr_d = head;
                  hold_d  = '0;
                  state_d = S_ISSUE;
               end else begin
                  bad_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (hold_done) begin
               res_data_d  = bus.result_in;
               res_dest_d  = instr_q[20:16];
               res_op_d    = instr_q[5:0];
               res_valid_d = 1'b1;
               hold_d      = '0;
               // Back-to-back only for a valid head; an invalid head is left for IDLE.
               if (bus.run && not_empty && head_ok) begin
                  pop     = 1'b1;
                  instr_d = head;
               end else begin
                  instr_d = '0;
                  state_d = S_IDLE;
               end
            end else begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         instr_q     <= '0;
         res_data_q  <= '0;
         res_dest_q  <= '0;
         res_op_q    <= '0;
         res_valid_q <= 1'b0;
         bad_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         instr_q     <= instr_d;
         res_data_q  <= res_data_d;
         res_dest_q  <= res_dest_d;
         res_op_q    <= res_op_d;
         res_valid_q <= res_valid_d;
         bad_q       <= bad_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.instr_out  = instr_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_dest   = res_dest_q;
   assign bus.res_opcode = res_op_q;
   assign bus.bad_opcode = bad_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.level      = level_q;
endmodule

// File: tb/tb_instr_issue_unit.sv
// Testbench for instr_issue_unit: a cycle-by-cycle vector table for the
// basic issue / back-to-back / bad-opcode flows, followed by directed
// sequences for FIFO full, reset during issue and run deassertion.
// The processor is modelled by a small register-file adder/subtractor
// driving result_in from instr_out.
module tb_instr_issue_unit;
   localparam int unsigned DEPTH        = 16;
   localparam int unsigned ISSUE_CYCLES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   instr_issue_unit_if #(.DEPTH(DEPTH)) bus ();

   instr_issue_unit #(.DEPTH(DEPTH), .ISSUE_CYCLES(ISSUE_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Processor model: fixed register contents; opcode 10 subtracts, others add.
   function automatic logic [31:0] reg_val(input logic [4:0] r);
      case (r)
         5'd0:    return 32'd1000;
         5'd10:   return 32'd4630;
         5'd1:    return 32'd1000;
         5'd9:    return 32'd3772;
         5'd2:    return 32'd2000;
         5'd8:    return 32'd3348;
         default: return 32'(r) * 32'd7 + 32'd11;
      endcase
   endfunction

   function automatic logic [31:0] proc_model(input logic [31:0] ins);
      logic [31:0] a, b;
      a = reg_val(ins[10:6]);
      b = reg_val(ins[15:11]);
      if (ins[5:0] == 6'd10) return a - b;
      return a + b;
   endfunction

   assign bus.result_in = proc_model(bus.instr_out);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        run;
      logic        in_valid;
      logic [31:0] in_instr;
      logic [31:0] e_instr_out;
      logic        e_res_valid;
      logic [31:0] e_res_data;
      logic [4:0]  e_dest;
      logic [5:0]  e_op;
      logic        e_bad;
      logic        e_busy;
      logic [4:0]  e_level;
      logic        e_ready;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic r, input logic rn, input logic iv, input logic [31:0] ii,
      input logic [31:0] eio, input logic erv, input logic [31:0] erd,
      input logic [4:0] ed, input logic [5:0] eo, input logic eb,
      input logic ebz, input logic [4:0] el, input logic er);
      vec_t v;
      v.rst = r; v.run = rn; v.in_valid = iv; v.in_instr = ii;
      v.e_instr_out = eio; v.e_res_valid = erv; v.e_res_data = erd;
      v.e_dest = ed; v.e_op = eo; v.e_bad = eb; v.e_busy = ebz;
      v.e_level = el; v.e_ready = er;
      return v;
   endfunction

   logic [31:0] words [17];
   logic [5:0]  ops [11];
   logic [31:0] issued[$];
   logic [31:0] prev_io;
   logic        rdy, pending;
   int unsigned nres;
   logic        over;

   initial begin
      bus.run      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;

      // rst run iv instr | instr_out rv res_data dest op bad busy level ready
      vq.push_back(mk(1,0,0,32'h0,        32'h0,        0,32'd0,        0, 0,0,0,0,1));
      vq.push_back(mk(0,1,1,32'h000d5004, 32'h0,        0,32'd0,        0, 0,0,0,1,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h000d5004, 0,32'd0,        0, 0,0,1,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h000d5004, 0,32'd0,        0, 0,0,1,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h0,        1,32'd5630,     13,4,0,0,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h0,        0,32'd5630,     13,4,0,0,0,1));
      vq.push_back(mk(0,1,1,32'h000e484a, 32'h0,        0,32'd5630,     13,4,0,0,1,1));
      vq.push_back(mk(0,1,1,32'h000f4083, 32'h000e484a, 0,32'd5630,     13,4,0,1,1,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h000e484a, 0,32'd5630,     13,4,0,1,1,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h000f4083, 1,32'hFFFFF52C, 14,10,0,1,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h000f4083, 0,32'hFFFFF52C, 14,10,0,1,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h0,        1,32'd5348,     15,3,0,0,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h0,        0,32'd5348,     15,3,0,0,0,1));
      vq.push_back(mk(0,1,1,32'h0000003F, 32'h0,        0,32'd5348,     15,3,0,0,1,1));
      vq.push_back(mk(0,1,1,32'h00000000, 32'h0,        0,32'd5348,     15,3,1,0,1,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h0,        0,32'd5348,     15,3,1,0,0,1));
      vq.push_back(mk(0,1,0,32'h0,        32'h0,        0,32'd5348,     15,3,0,0,0,1));

      for (int unsigned i = 0; i < vq.size(); i++) begin
         rst          = vq[i].rst;
         bus.run      = vq[i].run;
         bus.in_valid = vq[i].in_valid;
         bus.in_instr = vq[i].in_instr;
         @(posedge clk); #1;
         chk($sformatf("v%0d instr_out", i),  bus.instr_out,         vq[i].e_instr_out);
         chk($sformatf("v%0d res_valid", i),  32'(bus.res_valid),    32'(vq[i].e_res_valid));
         chk($sformatf("v%0d res_data", i),   bus.res_data,          vq[i].e_res_data);
         chk($sformatf("v%0d res_dest", i),   32'(bus.res_dest),     32'(vq[i].e_dest));
         chk($sformatf("v%0d res_opcode", i), 32'(bus.res_opcode),   32'(vq[i].e_op));
         chk($sformatf("v%0d bad_opcode", i), 32'(bus.bad_opcode),   32'(vq[i].e_bad));
         chk($sformatf("v%0d busy", i),       32'(bus.busy),         32'(vq[i].e_busy));
         chk($sformatf("v%0d level", i),      32'(bus.level),        32'(vq[i].e_level));
         chk($sformatf("v%0d in_ready", i),   32'(bus.in_ready),     32'(vq[i].e_ready));
      end

      // ---- FIFO full, 17th word held off, then all 17 issue in order ----
      ops = '{6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
      for (int unsigned i = 0; i < 17; i++)
         words[i] = {11'(i + 1), 5'(i), 5'(i + 1), 5'(i + 2), ops[i % 11]};
      rst = 1'b1; bus.run = 1'b0; bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = words[i];
         @(posedge clk); #1;
      end
      chk("full level", 32'(bus.level), 32'd16);
      chk("full in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_instr = words[16];
      @(posedge clk); #1;
      chk("17th ignored level", 32'(bus.level), 32'd16);
      bus.run = 1'b1;
      pending = 1'b1;
      prev_io = '0;
      nres    = 0;
      over    = 1'b0;
      for (int unsigned c = 0; c < 200 && nres < 17; c++) begin
         rdy = bus.in_ready;
         @(posedge clk); #1;
         if (pending && rdy) begin
            pending      = 1'b0;
            bus.in_valid = 1'b0;
         end
         if (bus.level > 5'd16) over = 1'b1;
         if (bus.instr_out != prev_io && bus.instr_out != 32'h0) issued.push_back(bus.instr_out);
         prev_io = bus.instr_out;
         if (bus.res_valid) begin
            if (nres < 17)
               chk($sformatf("fifo res_data %0d", nres), bus.res_data, proc_model(words[nres]));
            nres++;
         end
      end
      bus.in_valid = 1'b0;
      chk("fifo result count", nres, 32'd17);
      chk("fifo issued count", issued.size(), 32'd17);
      chk("fifo level bound", 32'(over), 32'd0);
      for (int unsigned i = 0; i < issued.size() && i < 17; i++)
         chk($sformatf("fifo order %0d", i), issued[i], words[i]);
      chk("fifo drained level", 32'(bus.level), 32'd0);

      // ---- reset in the 2nd hold cycle ----
      rst = 1'b1; bus.run = 1'b1; bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b1; bus.in_instr = words[0];
      @(posedge clk); #1;
      bus.in_instr = words[1];
      @(posedge clk); #1;
      chk("rstmid issue", bus.instr_out, words[0]);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid hold2", bus.instr_out, words[0]);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmid instr_out", bus.instr_out, 32'h0);
      chk("rstmid res_valid", 32'(bus.res_valid), 32'd0);
      chk("rstmid level", 32'(bus.level), 32'd0);
      chk("rstmid busy", 32'(bus.busy), 32'd0);
      chk("rstmid in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      chk("rstmid no late res_valid", 32'(bus.res_valid), 32'd0);

      // ---- drop run in the 1st hold cycle with 3 queued ----
      rst = 1'b1; bus.run = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_instr = words[i + 4];
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.run = 1'b1;
      @(posedge clk); #1;
      chk("runoff issue", bus.instr_out, words[4]);
      bus.run = 1'b0;
      @(posedge clk); #1;
      chk("runoff hold res_valid", 32'(bus.res_valid), 32'd0);
      @(posedge clk); #1;
      chk("runoff res_valid", 32'(bus.res_valid), 32'd1);
      chk("runoff res_data", bus.res_data, proc_model(words[4]));
      repeat (3) @(posedge clk);
      #1;
      chk("runoff level", 32'(bus.level), 32'd2);
      chk("runoff busy", 32'(bus.busy), 32'd0);
      chk("runoff instr_out", bus.instr_out, 32'h0);
      bus.run = 1'b1;
      nres = 0;
      for (int unsigned c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (bus.res_valid) nres++;
      end
      chk("runoff resumed results", nres, 32'd2);
      chk("runoff resumed level", 32'(bus.level), 32'd0);
      chk("runoff last dest", 32'(bus.res_dest), 32'(words[6][20:16]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
